// File: rtl/aibnd_dcc_pkg.sv
// rtl/aibnd_dcc_pkg.sv - shared types and defaults for the DCC calibration controller
//
// Purpose: FSM state encoding, DLL status width and parameter defaults used by
// aibnd_dcc_cal_ctrl and aibnd_dcc_sync.
// Ports: none (package).
package aibnd_dcc_pkg;

  localparam int DLL_STAT_W      = 13;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TMO_W_DEF       = 16;
  localparam int RETRY_MAX_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2,
    BACKOFF = 2'd3
  } dcc_state_e;

endpackage

// File: rtl/aibnd_dcc_sync.sv
// rtl/aibnd_dcc_sync.sv - multi-flop synchronizer for the asynchronous DCC done
//
// Purpose: brings d into the clk domain through SYNC_STAGES flops.
// Ports:
//   clk - core clock
//   rst - synchronous active-high reset, clears every stage
//   d   - asynchronous input
//   q   - synchronized output (last stage)
module aibnd_dcc_sync
  import aibnd_dcc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/aibnd_dcc_cal_ctrl.sv
// rtl/aibnd_dcc_cal_ctrl.sv - DCC calibration request/handshake controller
//
// Purpose: runs a four-phase req/done handshake with the DCC/DLL, with a per
// attempt timeout, bounded retries, abort/disable handling and sticky
// pass/fail flags. Captures the DLL status bus when done arrives.
// Ports:
//   clk, rst        - core clock, synchronous active-high reset
//   cal_start       - single-cycle start pulse (honoured only in IDLE)
//   cal_abort       - abandon calibration in progress
//   rb_dcc_en       - block enable
//   rb_dcc_timeout  - attempt timeout in cycles (0 behaves as 1)
//   dcc_done        - asynchronous done from the DCC/DLL
//   odll_dll2core   - DLL status bus
//   dcc_req         - registered request to the DCC
//   cal_busy        - high in every state except IDLE
//   cal_pass/fail   - sticky result flags, mutually exclusive
//   retry_cnt       - retries used
//   dll_status      - odll_dll2core captured when done was seen
module aibnd_dcc_cal_ctrl
  import aibnd_dcc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TMO_W       = TMO_W_DEF,
  parameter int RETRY_MAX   = RETRY_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cal_start,
  input  logic                  cal_abort,
  input  logic                  rb_dcc_en,
  input  logic [TMO_W-1:0]      rb_dcc_timeout,
  input  logic                  dcc_done,
  input  logic [DLL_STAT_W-1:0] odll_dll2core,
  output logic                  dcc_req,
  output logic                  cal_busy,
  output logic                  cal_pass,
  output logic                  cal_fail,
  output logic [1:0]            retry_cnt,
  output logic [DLL_STAT_W-1:0] dll_status
);

  // retry_cnt is two bits wide, so the limit is clamped to 3.
  localparam logic [2:0] RETRY_LIM = (RETRY_MAX > 3) ? 3'd3 : 3'(RETRY_MAX);

  logic done_s;

  aibnd_dcc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_done_sync (
    .clk(clk),
    .rst(rst),
    .d  (dcc_done),
    .q  (done_s)
  );

  dcc_state_e            state_d,     state_q;
  logic [TMO_W-1:0]      cnt_d,       cnt_q;
  logic                  req_d,       req_q;
  logic                  busy_d,      busy_q;
  logic                  pass_d,      pass_q;
  logic                  fail_d,      fail_q;
  logic [1:0]            retry_d,     retry_q;
  logic [DLL_STAT_W-1:0] dll_d,       dll_q;
  // Remembers that the current RELEASE/BACKOFF was caused by abort/disable,
  // so the exit reports fail instead of pass or retrying.
  logic                  aborted_d,   aborted_q;

  logic [TMO_W-1:0] tmo_eff;
  logic             timeout_hit;

  always_comb begin
    tmo_eff     = (rb_dcc_timeout == '0) ? TMO_W'(1) : rb_dcc_timeout;
    // Compare one bit wider so cnt_q+1 cannot wrap at the counter maximum.
    timeout_hit = (({1'b0, cnt_q} + (TMO_W+1)'(1)) >= {1'b0, tmo_eff});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
    dll_d     = dll_q;
    aborted_d = aborted_q;

    case (state_q)
      IDLE: begin
        if (cal_start && rb_dcc_en && !done_s) begin
          state_d   = ACTIVE;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          retry_d   = 2'd0;
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
      end
      ACTIVE: begin
        cnt_d = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + TMO_W'(1);
        if (cal_abort || !rb_dcc_en) begin
          state_d   = RELEASE;
          aborted_d = 1'b1;
        end else if (done_s) begin
          // Done beats a simultaneous timeout.
          state_d = RELEASE;
          dll_d   = odll_dll2core;
        end else if (timeout_hit) begin
          state_d = BACKOFF;
        end
      end
      RELEASE: begin
        if (!done_s) begin
          state_d = IDLE;
          if (aborted_q) begin
            fail_d = 1'b1;
          end else begin
            pass_d = 1'b1;
          end
        end
      end
      BACKOFF: begin
        if (cal_abort) begin
          aborted_d = 1'b1;
        end
        if (!done_s) begin
          if (cal_abort || aborted_q) begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end else if ({1'b0, retry_q} < RETRY_LIM) begin
            state_d = ACTIVE;
            retry_d = retry_q + 2'd1;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Request and busy are decoded from the next state so they are registered
    // alongside it; req is high exactly while the FSM sits in ACTIVE.
    req_d  = (state_d == ACTIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= 2'd0;
      dll_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      dll_q     <= dll_d;
      aborted_q <= aborted_d;
    end
  end

  assign dcc_req    = req_q;
  assign cal_busy   = busy_q;
  assign cal_pass   = pass_q;
  assign cal_fail   = fail_q;
  assign retry_cnt  = retry_q;
  assign dll_status = dll_q;

endmodule

// File: tb/tb_aibnd_dcc_cal_ctrl.sv
// tb/tb_aibnd_dcc_cal_ctrl.sv - directed self-checking bench for aibnd_dcc_cal_ctrl
module tb_aibnd_dcc_cal_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cal_start = 1'b0;
  logic        cal_abort = 1'b0;
  logic        rb_dcc_en = 1'b1;
  logic [15:0] rb_dcc_timeout = 16'd100;
  logic        dcc_done = 1'b0;
  logic [12:0] odll_dll2core = 13'h0;
  logic        dcc_req;
  logic        cal_busy;
  logic        cal_pass;
  logic        cal_fail;
  logic [1:0]  retry_cnt;
  logic [12:0] dll_status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aibnd_dcc_cal_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cal_start     (cal_start),
    .cal_abort     (cal_abort),
    .rb_dcc_en     (rb_dcc_en),
    .rb_dcc_timeout(rb_dcc_timeout),
    .dcc_done      (dcc_done),
    .odll_dll2core (odll_dll2core),
    .dcc_req       (dcc_req),
    .cal_busy      (cal_busy),
    .cal_pass      (cal_pass),
    .cal_fail      (cal_fail),
    .retry_cnt     (retry_cnt),
    .dll_status    (dll_status)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Request pulse monitor: counts rises and records each pulse length.
  int req_rises = 0;
  int req_lens[$];
  initial begin
    int  cur;
    logic mprev;
    cur   = 0;
    mprev = 1'b0;
    forever begin
      @(negedge clk);
      if (dcc_req && !mprev) begin
        req_rises++;
        cur = 1;
      end else if (dcc_req) begin
        cur++;
      end else if (mprev) begin
        req_lens.push_back(cur);
      end
      mprev = dcc_req;
    end
  end

  // DCC responder: raises done resp_delay cycles into attempt resp_att and
  // drops it 3 cycles after req falls. resp_stuck holds done high.
  logic resp_en    = 1'b0;
  logic resp_stuck = 1'b0;
  int   resp_att   = 0;
  int   resp_delay = 0;
  int   resp_attempts = 0;
  initial begin
    int   hi;
    int   lo;
    logic rprev;
    hi = 0;
    lo = 0;
    rprev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_stuck) begin
        dcc_done = 1'b1;
        lo = 0;
      end else if (dcc_req) begin
        if (!rprev) begin
          resp_attempts++;
          hi = 0;
        end
        hi++;
        if (resp_en && resp_attempts >= resp_att && hi == resp_delay) begin
          dcc_done = 1'b1;
          lo = 0;
        end
      end else if (dcc_done) begin
        lo++;
        if (lo == 3) begin
          dcc_done = 1'b0;
          lo = 0;
        end
      end
      rprev = dcc_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cal();
    tick();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic expired;
    expired = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!cal_busy) begin
        expired = 1'b0;
        break;
      end
    end
    check_eq(tag, {31'd0, expired}, 32'd0);
  endtask

  task automatic respond(input int attempt_offset, input int delay);
    resp_att   = resp_attempts + attempt_offset;
    resp_delay = delay;
    resp_en    = 1'b1;
  endtask

  initial begin
    int rb;
    int lb;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req",   {31'd0, dcc_req},  0);
    check_eq("rst_busy",  {31'd0, cal_busy}, 0);
    check_eq("rst_pass",  {31'd0, cal_pass}, 0);
    check_eq("rst_fail",  {31'd0, cal_fail}, 0);
    check_eq("rst_retry", {30'd0, retry_cnt}, 0);
    check_eq("rst_dll",   {19'd0, dll_status}, 0);

    // Nominal pass: done 20 cycles into the request, req visible 22 cycles
    rb_dcc_timeout = 16'd100;
    odll_dll2core  = 13'h0A5A;
    rb = req_rises; lb = req_lens.size();
    respond(1, 20);
    start_cal();
    wait_idle("nom_wait", 200);
    check_eq("nom_pass",  {31'd0, cal_pass}, 1);
    check_eq("nom_fail",  {31'd0, cal_fail}, 0);
    check_eq("nom_retry", {30'd0, retry_cnt}, 0);
    check_eq("nom_dll",   {19'd0, dll_status}, 32'h0A5A);
    check_eq("nom_rises", req_rises - rb, 1);
    if (req_lens.size() > lb) check_eq("nom_len", req_lens[lb], 22);
    else check_eq("nom_len_missing", req_lens.size() - lb, 1);
    odll_dll2core = 13'h1111;
    tick();
    check_eq("nom_dll_hold", {19'd0, dll_status}, 32'h0A5A);

    // Timeout with retries: 4 pulses of 10 cycles, then fail
    resp_en = 1'b0;
    rb_dcc_timeout = 16'd10;
    rb = req_rises; lb = req_lens.size();
    start_cal();
    wait_idle("tmo_wait", 300);
    check_eq("tmo_fail",  {31'd0, cal_fail}, 1);
    check_eq("tmo_pass",  {31'd0, cal_pass}, 0);
    check_eq("tmo_busy",  {31'd0, cal_busy}, 0);
    check_eq("tmo_retry", {30'd0, retry_cnt}, 3);
    check_eq("tmo_rises", req_rises - rb, 4);
    check_eq("tmo_npulse", req_lens.size() - lb, 4);
    for (int i = lb; i < req_lens.size(); i++) check_eq("tmo_len", req_lens[i], 10);

    // Retry success: attempt 1 silent, attempt 2 answered after 3 cycles
    odll_dll2core = 13'h0123;
    rb = req_rises; lb = req_lens.size();
    respond(2, 3);
    start_cal();
    wait_idle("rty_wait", 300);
    check_eq("rty_pass",  {31'd0, cal_pass}, 1);
    check_eq("rty_fail",  {31'd0, cal_fail}, 0);
    check_eq("rty_retry", {30'd0, retry_cnt}, 1);
    check_eq("rty_dll",   {19'd0, dll_status}, 32'h0123);
    check_eq("rty_npulse", req_lens.size() - lb, 2);
    if (req_lens.size() >= lb + 2) begin
      check_eq("rty_len0", req_lens[lb], 10);
      check_eq("rty_len1", req_lens[lb+1], 5);
    end

    // Collision: done_s rises on the timeout cycle, done wins
    odll_dll2core = 13'h1111;
    rb = req_rises; lb = req_lens.size();
    respond(1, 8);
    start_cal();
    wait_idle("col_wait", 200);
    check_eq("col_pass",  {31'd0, cal_pass}, 1);
    check_eq("col_retry", {30'd0, retry_cnt}, 0);
    check_eq("col_dll",   {19'd0, dll_status}, 32'h1111);
    check_eq("col_rises", req_rises - rb, 1);
    if (req_lens.size() > lb) check_eq("col_len", req_lens[lb], 10);

    // Timeout of 0 behaves as 1
    resp_en = 1'b0;
    rb_dcc_timeout = 16'd0;
    odll_dll2core = 13'h0777;
    rb = req_rises; lb = req_lens.size();
    start_cal();
    wait_idle("t0_wait", 100);
    check_eq("t0_fail",  {31'd0, cal_fail}, 1);
    check_eq("t0_retry", {30'd0, retry_cnt}, 3);
    check_eq("t0_npulse", req_lens.size() - lb, 4);
    for (int i = lb; i < req_lens.size(); i++) check_eq("t0_len", req_lens[i], 1);
    check_eq("t0_dll", {19'd0, dll_status}, 32'h1111);

    // Abort at cycle 5 of ACTIVE
    rb_dcc_timeout = 16'd100;
    start_cal();
    @(negedge clk);
    check_eq("abt_req_on", {31'd0, dcc_req}, 1);
    tick(); tick(); tick();
    cal_abort = 1'b1;
    tick();
    cal_abort = 1'b0;
    @(negedge clk);
    check_eq("abt_req_off", {31'd0, dcc_req}, 0);
    check_eq("abt_busy",    {31'd0, cal_busy}, 1);
    wait_idle("abt_wait", 20);
    check_eq("abt_fail", {31'd0, cal_fail}, 1);
    check_eq("abt_pass", {31'd0, cal_pass}, 0);
    check_eq("abt_dll",  {19'd0, dll_status}, 32'h1111);

    // Disable at cycle 5 of ACTIVE
    start_cal();
    repeat (3) tick();
    rb_dcc_en = 1'b0;
    tick();
    @(negedge clk);
    check_eq("dis_req_off", {31'd0, dcc_req}, 0);
    wait_idle("dis_wait", 20);
    rb_dcc_en = 1'b1;
    check_eq("dis_fail", {31'd0, cal_fail}, 1);
    check_eq("dis_pass", {31'd0, cal_pass}, 0);

    // Reset at cycle 5 of ACTIVE
    start_cal();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("mrst_req",   {31'd0, dcc_req},  0);
    check_eq("mrst_busy",  {31'd0, cal_busy}, 0);
    check_eq("mrst_pass",  {31'd0, cal_pass}, 0);
    check_eq("mrst_fail",  {31'd0, cal_fail}, 0);
    check_eq("mrst_retry", {30'd0, retry_cnt}, 0);
    check_eq("mrst_dll",   {19'd0, dll_status}, 0);
    rst = 1'b0;
    tick();

    // Start ignored while disabled
    rb_dcc_en = 1'b0;
    start_cal();
    @(negedge clk);
    check_eq("en0_busy", {31'd0, cal_busy}, 0);
    rb_dcc_en = 1'b1;

    // Start ignored while busy: only one request pulse
    rb = req_rises;
    respond(1, 20);
    start_cal();
    repeat (4) tick();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    wait_idle("busy_wait", 200);
    check_eq("busy_rises", req_rises - rb, 1);
    check_eq("busy_pass",  {31'd0, cal_pass}, 1);

    // Start ignored while done is stuck high
    resp_en = 1'b0;
    resp_stuck = 1'b1;
    rb = req_rises;
    repeat (5) tick();
    start_cal();
    repeat (3) @(negedge clk);
    check_eq("stk_busy",  {31'd0, cal_busy}, 0);
    check_eq("stk_rises", req_rises - rb, 0);
    check_eq("stk_pass",  {31'd0, cal_pass}, 1);
    resp_stuck = 1'b0;
    repeat (8) tick();
    check_eq("stk_done_low", {31'd0, dcc_done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Pass and fail must never be asserted together.
  always @(negedge clk) begin
    if (cal_pass && cal_fail) begin
      check_eq("pass_fail_excl", {31'd0, cal_fail}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "bench timeout");
  end

endmodule
